matrix_reg_stream: RTL and testbench

Parametrised ROWS×COLS matrix of DW-bit registers with an independent write port and a streamed read port. It supports single-element reads and whole-row or whole-column bursts under valid/ready backpressure, plus a one-cycle global clear. It is the generalised successor of the fixed 12×12×36 register array and sits between the matrix-fill logic (write side) and the downstream compute/streaming consumers (read side).

---
 rtl/matrix_reg_stream_pkg.sv | 24 ++
 rtl/matrix_reg_stream_if.sv | 17 +
 rtl/matrix_reg_stream_store.sv | 45 ++++
 rtl/matrix_reg_stream.sv | 189 ++++++++++++++++++
 tb/tb_matrix_reg_stream.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_reg_stream_pkg.sv
// Shared types for the streamed register matrix.
//   rd_mode_e : read request modes (single cell, row burst, column burst)
//   state_e   : read FSM states
//   MODE_RSVD : the reserved rd_mode encoding, always rejected
package matrix_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_ROW    = 2'd1,
    MODE_COL    = 2'd2
  } rd_mode_e;

  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matrix_reg_stream_if.sv
// Read-side stream of the register matrix.
//   out_valid : beat valid
//   out_ready : consumer accepts beat
//   out_data  : beat data (0 while out_valid=0)
//   out_last  : final beat of the request
// master = matrix (producer), slave = consumer.
interface matrix_reg_stream_if #(
  parameter int unsigned DW = 36
) ();
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/matrix_reg_stream_store.sv
// ROWS x COLS flop storage of DW-bit cells.
//   clk, rst_n         : clock, synchronous active-low reset (all cells to 0)
//   clr                : synchronous clear of all cells, beats a same-cycle write
//   wr_en/row/col/data : write port; out-of-range addresses are dropped
//   rd_row/rd_col      : combinational read address
//   rd_data            : cell contents at the read address
module matrix_store
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = 12,
  parameter int unsigned COLS = 12,
  parameter int unsigned DW   = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [$clog2(COLS)-1:0]  wr_col,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem [ROWS][COLS];

  logic wr_ok;
  assign wr_ok = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/matrix_reg_stream.sv
// ROWS x COLS matrix of DW-bit registers with an independent write port and a
// streamed read port (single cell, row burst, column burst) under valid/ready.
//   clk, rst_n          : clock, synchronous active-low reset
//   clr                 : one-cycle clear of all cells (FSM unaffected)
//   wr_en/row/col/data  : write port, accepted in every state
//   rd_req/mode/row/col : read request, sampled only while idle
//   stream              : output beats (out_valid/out_ready/out_data/out_last)
//   busy                : request in flight, new requests ignored
//   err                 : one-cycle pulse after a rejected request
module matrix_reg_stream
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = 12,
  parameter int unsigned COLS = 12,
  parameter int unsigned DW   = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [$clog2(COLS)-1:0]  wr_col,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_req,
  input  logic [1:0]               rd_mode,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  matrix_reg_stream_if.master      stream,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned RAW = $clog2(ROWS);
  localparam int unsigned CAW = $clog2(COLS);
  localparam int unsigned KW  = max_u(RAW, CAW);

  state_e         state_q, state_d;
  rd_mode_e       mode_q, mode_d;
  logic [RAW-1:0] row_q, row_d;
  logic [CAW-1:0] col_q, col_d;
  logic [KW-1:0]  k_q, k_d;
  logic           valid_q, valid_d;
  logic [DW-1:0]  data_q, data_d;
  logic           last_q, last_d;
  logic           err_q, err_d;

  logic [1:0]     ld_mode;
  logic [KW-1:0]  ld_idx;
  logic [RAW-1:0] ld_row;
  logic [CAW-1:0] ld_col;
  logic           ld_last;
  logic [DW-1:0]  rd_q;
  logic [DW-1:0]  ld_data;
  logic           req_ok;

  function automatic int unsigned beat_count(input logic [1:0] m);
    case (m)
      MODE_ROW: return COLS;
      MODE_COL: return ROWS;
      default:  return 1;
    endcase
  endfunction

  matrix_store #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DW   (DW)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (ld_row),
    .rd_col  (ld_col),
    .rd_data (rd_q)
  );

  // Address of the beat that would load at the coming edge: beat 0 of the
  // incoming request while idle, beat k+1 of the latched request otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      ld_mode = rd_mode;
      ld_idx  = '0;
      ld_row  = rd_row;
      ld_col  = rd_col;
    end else begin
      ld_mode = mode_q;
      ld_idx  = KW'(k_q + 1'b1);
      ld_row  = row_q;
      ld_col  = col_q;
    end
    case (ld_mode)
      MODE_ROW: ld_col = CAW'(ld_idx);
      MODE_COL: ld_row = RAW'(ld_idx);
      default:  ;
    endcase
  end

  assign ld_last = (32'(ld_idx) == beat_count(ld_mode) - 1);

  // Write-through: a same-edge clear or write to the loading cell wins over
  // the stored value, so the beat matches what the cell holds afterwards.
  assign ld_data = clr ? '0 :
                   (wr_en && wr_row == ld_row && wr_col == ld_col) ? wr_data : rd_q;

  // Only the indices the mode actually uses are range-checked.
  assign req_ok = (rd_mode != MODE_RSVD)
               && ((rd_mode == MODE_COL) || (32'(rd_row) < ROWS))
               && ((rd_mode == MODE_ROW) || (32'(rd_col) < COLS));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (req_ok) begin
            state_d = STREAM;
            mode_d  = rd_mode_e'(rd_mode);
            row_d   = rd_row;
            col_d   = rd_col;
            k_d     = '0;
            valid_d = 1'b1;
            data_d  = ld_data;
            last_d  = ld_last;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (valid_q && stream.out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            k_d     = KW'(k_q + 1'b1);
            data_d  = ld_data;
            last_d  = ld_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_SINGLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_data  = data_q;
  assign stream.out_last  = last_q;
  assign busy             = (state_q == STREAM);
  assign err              = err_q;

endmodule

// File: tb/tb_matrix_reg_stream.sv
module tb_matrix_reg_stream;

  localparam int unsigned ROWS = 12;
  localparam int unsigned COLS = 12;
  localparam int unsigned DW   = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_row = '0;
  logic [3:0]    wr_col = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic [1:0]    rd_mode = '0;
  logic [3:0]    rd_row = '0;
  logic [3:0]    rd_col = '0;
  logic          busy;
  logic          err;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  matrix_reg_stream_if #(.DW(DW)) stream ();

  matrix_reg_stream #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DW   (DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_mode (rd_mode),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .stream  (stream),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int unsigned r, input int unsigned c, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_row  = 4'(r);
    wr_col  = 4'(c);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic request(input logic [1:0] m, input int unsigned r, input int unsigned c);
    rd_req  = 1'b1;
    rd_mode = m;
    rd_row  = 4'(r);
    rd_col  = 4'(c);
    tick();
    rd_req  = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    int unsigned e;
    logic [DW-1:0] exp_d;

    stream.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_valid", stream.out_valid, 1'b0);
    chk("rst_data", stream.out_data, '0);
    chk("rst_last", stream.out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);

    // Single read [0][0] after reset
    request(2'd0, 0, 0);
    chk("s00_valid", stream.out_valid, 1'b1);
    chk("s00_data", stream.out_data, '0);
    chk("s00_last", stream.out_last, 1'b1);
    chk("s00_busy", busy, 1'b1);
    stream.out_ready = 1'b1;
    tick();
    chk("s00_end_valid", stream.out_valid, 1'b0);
    chk("s00_end_busy", busy, 1'b0);

    // Write then single read [3][5]
    write(3, 5, 36'h0_ABCD_1234);
    request(2'd0, 3, 5);
    chk("s35_data", stream.out_data, 36'h0_ABCD_1234);
    chk("s35_last", stream.out_last, 1'b1);
    tick();
    chk("s35_end_valid", stream.out_valid, 1'b0);

    // Fill cell [r][c] = r*16+c
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        write(r, c, DW'(r * 16 + c));

    // Row burst on row 7, no backpressure
    request(2'd1, 7, 0);
    for (int unsigned k = 0; k < COLS; k++) begin
      chk("row7_valid", stream.out_valid, 1'b1);
      chk("row7_data", stream.out_data, 64'(8'h70 + k));
      chk("row7_last", stream.out_last, 64'(k == COLS - 1));
      tick();
    end
    chk("row7_end_valid", stream.out_valid, 1'b0);
    chk("row7_end_busy", busy, 1'b0);

    // Column burst on column 2 with ready pattern 1,0,0,1...
    pat = 4'b1001;
    e = 0;
    stream.out_ready = 1'b0;
    request(2'd2, 0, 2);
    for (int i = 0; i < 100 && e < ROWS; i++) begin
      stream.out_ready = pat[i % 4];
      chk("col2_valid", stream.out_valid, 1'b1);
      chk("col2_data", stream.out_data, 64'(e * 16 + 2));
      chk("col2_last", stream.out_last, 64'(e == ROWS - 1));
      if (stream.out_ready) e++;
      tick();
    end
    chk("col2_count", e, 12);
    chk("col2_end_valid", stream.out_valid, 1'b0);

    // Row-4 burst: write-through on beat 9, clear before beat 10 loads
    stream.out_ready = 1'b1;
    request(2'd1, 4, 0);
    for (int unsigned k = 0; k < COLS; k++) begin
      if (k < 9)       exp_d = DW'(8'h40 + k);
      else if (k == 9) exp_d = 36'h55;
      else             exp_d = '0;
      chk("row4_data", stream.out_data, exp_d);
      if (k == 8) begin
        wr_en = 1'b1; wr_row = 4'd4; wr_col = 4'd9; wr_data = 36'h55;
      end
      if (k == 9) clr = 1'b1;
      tick();
      wr_en = 1'b0;
      clr   = 1'b0;
    end
    chk("row4_end_valid", stream.out_valid, 1'b0);
    request(2'd0, 7, 3);
    chk("after_clr_data", stream.out_data, '0);
    tick();

    // Rejections
    request(2'd3, 0, 0);
    chk("rsvd_err", err, 1'b1);
    chk("rsvd_valid", stream.out_valid, 1'b0);
    chk("rsvd_busy", busy, 1'b0);
    tick();
    chk("rsvd_err_pulse", err, 1'b0);
    request(2'd0, 12, 0);
    chk("row12_err", err, 1'b1);
    chk("row12_valid", stream.out_valid, 1'b0);
    tick();
    request(2'd1, 12, 0);
    chk("rowburst12_err", err, 1'b1);
    chk("rowburst12_valid", stream.out_valid, 1'b0);
    tick();

    // Row burst ignores an out-of-range column
    write(1, 11, 36'h99);
    request(2'd1, 1, 15);
    chk("row1_err", err, 1'b0);
    for (int unsigned k = 0; k < COLS; k++) begin
      chk("row1_data", stream.out_data, (k == COLS - 1) ? 64'h99 : 64'h0);
      tick();
    end
    chk("row1_end_valid", stream.out_valid, 1'b0);

    // Request while busy is ignored without err; reset aborts the burst
    write(0, 0, 36'h123);
    stream.out_ready = 1'b0;
    request(2'd2, 0, 0);
    chk("busy_data", stream.out_data, 36'h123);
    chk("busy_last", stream.out_last, 1'b0);
    request(2'd3, 0, 0);
    chk("busy_err", err, 1'b0);
    chk("busy_valid", stream.out_valid, 1'b1);
    chk("busy_hold", stream.out_data, 36'h123);
    rst_n = 1'b0;
    tick();
    chk("abort_valid", stream.out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", stream.out_data, '0);
    rst_n = 1'b1;
    stream.out_ready = 1'b1;
    request(2'd0, 0, 0);
    chk("abort_cell_valid", stream.out_valid, 1'b1);
    chk("abort_cell_data", stream.out_data, '0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
